// File: rtl/timer_entry.sv
// Keypad MM:SS entry buffer and load/run controller for the countdown chain.
// Digits shift in from the right; start validates, strobes loadn for one cycle, then enables counting.
module timer_entry #(
  parameter int MAX_SEC_TENS = 5
) (
  input  logic       clk,
  input  logic       clearn,
  input  logic       key_valid,
  input  logic [3:0] key,
  input  logic       start,
  input  logic       cancel,
  input  logic       timer_zero,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       loadn,
  output logic       en,
  output logic       done,
  output logic       err,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [3:0] MaxSecTens = 4'(MAX_SEC_TENS);

  state_e     state_q, state_d;
  // Index 0 is min_tens, index 3 is sec_units (newest digit).
  logic [3:0] dig_q [4];
  logic [3:0] dig_d [4];
  logic       loadn_q;
  logic       done_q;
  logic       err_q, err_d;
  logic       entry_zero;
  logic       entry_bad;
  logic       key_ok;

  assign entry_zero = (dig_q[0] == 4'd0) && (dig_q[1] == 4'd0) &&
                      (dig_q[2] == 4'd0) && (dig_q[3] == 4'd0);
  assign entry_bad  = entry_zero || (dig_q[2] > MaxSecTens);
  assign key_ok     = (key <= 4'd9);

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    for (int i = 0; i < 4; i++) dig_d[i] = dig_q[i];

    if (cancel) begin
      state_d = ST_IDLE;
      for (int i = 0; i < 4; i++) dig_d[i] = 4'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // start wins over a coincident key; validation uses the pre-shift buffer
          if (start) begin
            if (entry_bad) err_d = 1'b1;
            else           state_d = ST_LOAD;
          end else if (key_valid) begin
            if (key_ok) begin
              for (int i = 0; i < 3; i++) dig_d[i] = dig_q[i+1];
              dig_d[3] = key;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        ST_LOAD: state_d = ST_RUN;
        ST_RUN: begin
          if (timer_zero) state_d = ST_DONE;
        end
        ST_DONE: begin
          // The kept entry was already validated, so a restart reloads it directly.
          if (start) begin
            state_d = ST_LOAD;
          end else if (key_valid) begin
            if (key_ok) begin
              for (int i = 0; i < 3; i++) dig_d[i] = 4'd0;
              dig_d[3] = key;
              state_d  = ST_IDLE;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state_q <= ST_IDLE;
      loadn_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      loadn_q <= (state_d != ST_LOAD);
      done_q  <= (state_d == ST_DONE);
      err_q   <= err_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dig
      always_ff @(posedge clk or negedge clearn) begin
        if (!clearn) dig_q[gi] <= 4'd0;
        else         dig_q[gi] <= dig_d[gi];
      end
    end
  endgenerate

  assign min_tens  = dig_q[0];
  assign min_units = dig_q[1];
  assign sec_tens  = dig_q[2];
  assign sec_units = dig_q[3];
  assign loadn     = loadn_q;
  assign done      = done_q;
  assign err       = err_q;
  assign state     = state_q;
  // Combinational so the chain stops in the same cycle zero is reported or reset falls.
  assign en        = (state_q == ST_RUN) && !timer_zero;

endmodule

// File: tb/tb_timer_entry.sv
// Self-checking bench for timer_entry: vector table for entry/validation, hand sequences for load/run/priority/reset.
module tb_timer_entry;

  logic       clk = 1'b0;
  logic       clearn;
  logic       key_valid, start, cancel, timer_zero;
  logic [3:0] key;
  logic [3:0] min_tens, min_units, sec_tens, sec_units;
  logic       loadn, en, done, err;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        kv;
    logic [3:0]  key;
    logic        st;
    logic        cn;
    logic        tz;
    logic [15:0] dig;
    logic [1:0]  s;
    logic        ld;
    logic        en;
    logic        dn;
    logic        er;
  } vec_t;

  vec_t tbl [16];
  vec_t sb_q [$];

  timer_entry #(.MAX_SEC_TENS(5)) dut (
    .clk(clk), .clearn(clearn), .key_valid(key_valid), .key(key),
    .start(start), .cancel(cancel), .timer_zero(timer_zero),
    .min_tens(min_tens), .min_units(min_units), .sec_tens(sec_tens),
    .sec_units(sec_units), .loadn(loadn), .en(en), .done(done),
    .err(err), .state(state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic kv, logic [3:0] k, logic st, logic cn, logic tz,
                              logic [15:0] dig, logic [1:0] s, logic ld, logic e,
                              logic dn, logic er);
    vec_t v;
    v.kv = kv; v.key = k; v.st = st; v.cn = cn; v.tz = tz;
    v.dig = dig; v.s = s; v.ld = ld; v.en = e; v.dn = dn; v.er = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs(input string tag, input vec_t v);
    check({tag, " digits"}, {min_tens, min_units, sec_tens, sec_units}, v.dig);
    check({tag, " state"}, 16'(state), 16'(v.s));
    check({tag, " loadn"}, 16'(loadn), 16'(v.ld));
    check({tag, " en"},    16'(en),    16'(v.en));
    check({tag, " done"},  16'(done),  16'(v.dn));
    check({tag, " err"},   16'(err),   16'(v.er));
  endtask

  // Drive one cycle of stimulus at the negedge, queue its expectation, compare after the edge.
  task automatic step(input string tag, input vec_t v);
    vec_t e;
    key_valid = v.kv; key = v.key; start = v.st; cancel = v.cn; timer_zero = v.tz;
    sb_q.push_back(v);
    @(posedge clk);
    @(negedge clk);
    e = sb_q.pop_front();
    compare_outputs(tag, e);
    $display("step %-10s kv=%0b key=%h st=%0b cn=%0b tz=%0b -> dig=%h s=%0d ld=%0b en=%0b dn=%0b er=%0b",
             tag, v.kv, v.key, v.st, v.cn, v.tz,
             {min_tens, min_units, sec_tens, sec_units}, state, loadn, en, done, err);
  endtask

  task automatic hs(input string tag, input logic kv, input logic [3:0] k, input logic st,
                    input logic cn, input logic tz, input logic [15:0] dig, input logic [1:0] s,
                    input logic ld, input logic e, input logic dn, input logic er);
    step(tag, mk(kv, k, st, cn, tz, dig, s, ld, e, dn, er));
  endtask

  initial begin
    //             kv key   st cn tz  digits    s  ld en dn er
    tbl[0]  = mk(1, 4'h1, 0, 0, 0, 16'h0001, 0, 1, 0, 0, 0);
    tbl[1]  = mk(1, 4'h2, 0, 0, 0, 16'h0012, 0, 1, 0, 0, 0);
    tbl[2]  = mk(1, 4'h3, 0, 0, 0, 16'h0123, 0, 1, 0, 0, 0);
    tbl[3]  = mk(1, 4'h0, 0, 0, 0, 16'h1230, 0, 1, 0, 0, 0);
    tbl[4]  = mk(1, 4'h5, 0, 0, 0, 16'h2305, 0, 1, 0, 0, 0);
    tbl[5]  = mk(1, 4'hA, 0, 0, 0, 16'h2305, 0, 1, 0, 0, 1);
    tbl[6]  = mk(0, 4'h0, 0, 0, 0, 16'h2305, 0, 1, 0, 0, 0);
    tbl[7]  = mk(0, 4'h0, 0, 1, 0, 16'h0000, 0, 1, 0, 0, 0);
    tbl[8]  = mk(0, 4'h0, 1, 0, 0, 16'h0000, 0, 1, 0, 0, 1);
    tbl[9]  = mk(1, 4'h7, 0, 0, 0, 16'h0007, 0, 1, 0, 0, 0);
    tbl[10] = mk(1, 4'h0, 0, 0, 0, 16'h0070, 0, 1, 0, 0, 0);
    tbl[11] = mk(0, 4'h0, 1, 0, 0, 16'h0070, 0, 1, 0, 0, 1);
    tbl[12] = mk(0, 4'h0, 0, 0, 0, 16'h0070, 0, 1, 0, 0, 0);
    tbl[13] = mk(1, 4'h5, 0, 1, 0, 16'h0000, 0, 1, 0, 0, 0);
    tbl[14] = mk(1, 4'h1, 0, 0, 0, 16'h0001, 0, 1, 0, 0, 0);
    tbl[15] = mk(1, 4'h5, 0, 0, 0, 16'h0015, 0, 1, 0, 0, 0);

    clearn = 1'b0; key_valid = 0; key = 0; start = 0; cancel = 0; timer_zero = 0;
    repeat (2) @(negedge clk);
    compare_outputs("reset", mk(0, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 0));
    clearn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) step($sformatf("vec%0d", i), tbl[i]);

    // Load and run 0,0,1,5 for 15 enabled cycles.
    hs("load",  0, 0, 1, 0, 0, 16'h0015, 1, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) hs("run", 0, 0, 0, 0, 0, 16'h0015, 2, 1, 1, 0, 0);
    timer_zero = 1'b1;
    #1;
    check("zero_en_comb", 16'(en), 16'h0);
    check("zero_state", 16'(state), 16'h2);
    hs("zero",  0, 0, 0, 0, 1, 16'h0015, 3, 1, 0, 1, 0);
    hs("hold",  0, 0, 0, 0, 0, 16'h0015, 3, 1, 0, 1, 0);

    // Restart from DONE, then leave DONE with a key.
    hs("reload", 0, 0, 1, 0, 0, 16'h0015, 1, 0, 0, 0, 0);
    hs("rerun",  0, 0, 0, 0, 0, 16'h0015, 2, 1, 1, 0, 0);
    hs("rezero", 0, 0, 0, 0, 1, 16'h0015, 3, 1, 0, 1, 0);
    hs("donekey", 1, 4, 0, 0, 0, 16'h0004, 0, 1, 0, 0, 0);

    // Priority: start beats key in IDLE; cancel beats start in RUN.
    hs("clr",     0, 0, 0, 1, 0, 16'h0000, 0, 1, 0, 0, 0);
    hs("key3",    1, 3, 0, 0, 0, 16'h0003, 0, 1, 0, 0, 0);
    hs("st+key",  1, 9, 1, 0, 0, 16'h0003, 1, 0, 0, 0, 0);
    hs("run3",    0, 0, 0, 0, 0, 16'h0003, 2, 1, 1, 0, 0);
    hs("runkey",  1, 8, 1, 0, 0, 16'h0003, 2, 1, 1, 0, 0);
    hs("cn+st",   0, 0, 1, 1, 0, 16'h0000, 0, 1, 0, 0, 0);

    // Asynchronous reset in the middle of RUN.
    hs("k1",      1, 1, 0, 0, 0, 16'h0001, 0, 1, 0, 0, 0);
    hs("k5",      1, 5, 0, 0, 0, 16'h0015, 0, 1, 0, 0, 0);
    hs("ld2",     0, 0, 1, 0, 0, 16'h0015, 1, 0, 0, 0, 0);
    hs("run2",    0, 0, 0, 0, 0, 16'h0015, 2, 1, 1, 0, 0);
    #2 clearn = 1'b0;
    #1;
    compare_outputs("async", mk(0, 0, 0, 0, 0, 16'h0000, 0, 1, 0, 0, 0));
    @(negedge clk);
    clearn = 1'b1;

    // Seconds-tens at the legal maximum with key 9 is accepted.
    hs("k5b",     1, 5, 0, 0, 0, 16'h0005, 0, 1, 0, 0, 0);
    hs("k9",      1, 9, 0, 0, 0, 16'h0059, 0, 1, 0, 0, 0);
    hs("ld59",    0, 0, 1, 0, 0, 16'h0059, 1, 0, 0, 0, 0);
    hs("run59",   0, 0, 0, 0, 0, 16'h0059, 2, 1, 1, 0, 0);
    hs("cn59",    0, 0, 0, 1, 0, 16'h0000, 0, 1, 0, 0, 0);

    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: got %0d leftover entries expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_entry.md
# timer_entry

Keypad time-entry and load controller for the countdown timer chain. Collects BCD digits into a four-digit MM:SS buffer and validates the entry. On start, it drives the buffered digits onto the chain's parallel-load inputs with a one-cycle active-low load strobe, then enables counting until the chain reports zero. It is the writer side of the counter chain's `data`/`loadn`/`en`/`zero` interface.

## Interface
Parameters:
- `MAX_SEC_TENS`, default 5: largest legal seconds-tens digit; larger values are rejected at start.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clearn`  in  1  one clock; reset is asynchronous and active-low.
- `key_valid`  in  1  one-cycle strobe; `key` is valid.
- `key`  in  4  BCD digit from the keypad.
- `start`  in  1  one-cycle strobe; load and begin countdown.
- `cancel`  in  1  one-cycle strobe; abort and clear.
- `timer_zero`  in  1  all counter-chain digits are zero (AND of the digit `zero` flags).
- `min_tens`, `min_units`, `sec_tens`, `sec_units`  out  4 each  buffered digits, driven to the chain `data` inputs.
- `loadn`  out  1  active-low parallel-load strobe to the chain.
- `en`  out  1  count enable to the chain.
- `done`  out  1  countdown finished; held high.
- `err`  out  1  one-cycle pulse on a rejected key or start.
- `state`  out  2  current FSM state, for debug.

## Operation
- States are IDLE=0, LOAD=1, RUN=2, DONE=3.
- IDLE, `key_valid` with `key` ≤ 9:
  - Left shift: `min_tens`←`min_units`←`sec_tens`←`sec_units`←`key`.
  - A 5th or later digit discards the oldest digit.
- IDLE, `key_valid` with `key` > 9: buffer unchanged; `err` pulses.
- IDLE, `start`:
  - Buffer all zero, or `sec_tens` > `MAX_SEC_TENS`: stay in IDLE; `err` pulses.
  - Otherwise: go to LOAD.
- LOAD lasts exactly one cycle:
  - `loadn`=0, `en`=0; the digits are stable on the outputs.
  - Next state is RUN.
- RUN:
  - `en` = (state==RUN) && !`timer_zero`. This is the only combinational output.
  - When `timer_zero`=1, go to DONE on the next edge.
  - `key_valid` and `start` are ignored.
- DONE: `done`=1, `en`=0; the buffer keeps the last entry.
  - `key_valid` → clear the buffer, shift in the key, go to IDLE.
  - `start` → go to LOAD, which reloads the same entry.
- `cancel` in any state: clear the buffer to 0, deassert `done`, go to IDLE.
- Simultaneous events:
  - `cancel` beats `start` and `key_valid`.
  - In IDLE, `start` beats `key_valid`. The start is evaluated on the pre-shift buffer and the key is dropped.
- Digits are 4-bit BCD with no arithmetic. The buffer changes only by shift, clear, or reset.

## Timing
- Reset values, applied asynchronously on `clearn`=0:
  - state IDLE; all digits 0.
  - `loadn`=1, `en`=0, `done`=0, `err`=0.
- Reset during LOAD or RUN aborts immediately. `en` drops in the same cycle `clearn` falls.
- A key accepted at edge N appears on the digit outputs after edge N.
- `start` sampled at edge N:
  - `loadn`=0 during cycle N+1.
  - `en`=1 from cycle N+2, when the chain has the loaded value.
- `timer_zero` is first examined in the cycle after LOAD. Stale zero from before the load cannot occur, because an all-zero entry is rejected.
- `err` is registered and asserted for exactly the cycle after the offending edge.
- `done` rises the cycle after `timer_zero` is seen in RUN.

## Test plan
- Entry shift: reset, then keys 1,2,3,0 → digits `min_tens`..`sec_units` = 1,2,3,0. Then key 5 → digits 2,3,0,5.
- Bad input: key 4'hA → `err` pulses 1 cycle, digits unchanged. Buffer 0,0,7,0 with `start` → `err` pulses, state stays 0, `loadn` stays 1.
- Load/run: buffer 0,0,1,5 with `start` → `loadn` low for exactly 1 cycle with `data`=0,0,1,5. Then `en`=1 until `timer_zero` is forced high after 15 cycles. Then `en`=0 and `done`=1 the next cycle.
- Priority: in IDLE, assert `start` and `key_valid`(9) together with buffer 0,0,0,3 → LOAD with 0,0,0,3. In RUN, assert `cancel` and `start` together → IDLE, digits 0.
- Async reset: pulse `clearn` low mid-RUN between clock edges → `en`=0, `loadn`=1, `done`=0, digits 0 before the next edge.
- Restart: in DONE, `start` → LOAD with the previous entry. `key_valid`(4) instead → IDLE with digits 0,0,0,4 and `done`=0.
